spatz_barrier_responder: RTL and testbench
==========================================

SPATZ_BARRIER_RESPONDER -- requirements
Module: spatz_barrier_responder

Interface
REQ-001 SHALL have parameter NrPorts, default 4, meaning number of core request ports (1..32).
REQ-002 SHALL have parameter AddrWidth, default 32, meaning request address width.
REQ-003 SHALL have parameter DataWidth, default 32, meaning response data width (>= 8).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port barrier_addr_i  input  AddrWidth  barrier register address.
REQ-007 SHALL have port participate_i  input  NrPorts  ports taking part in the barrier.
REQ-008 SHALL have port req_valid_i  input  NrPorts  per-port request valid.
REQ-009 SHALL have port req_ready_o  output  NrPorts  per-port request ready.
REQ-010 SHALL have port req_addr_i  input  NrPorts x AddrWidth  per-port request address.
REQ-011 SHALL have port req_write_i  input  NrPorts  per-port write flag.
REQ-012 SHALL have port rsp_valid_o  output  NrPorts  per-port response valid.
REQ-013 SHALL have port rsp_ready_i  input  NrPorts  per-port response ready.
REQ-014 SHALL have port rsp_data_o  output  NrPorts x DataWidth  per-port response data.
REQ-015 SHALL have port rsp_error_o  output  NrPorts  per-port response error flag.
REQ-016 SHALL have port generation_o  output  8  completed-barrier count.
REQ-017 SHALL have port release_o  output  1  one-cycle pulse when barrier releases.

Function
REQ-018 SHALL keep one FSM per port: Idle, Arrived, Respond.
REQ-019 SHALL drive req_ready_o[i]=1 only in Idle; handshake = req_valid_i & req_ready_o.
REQ-020 SHALL classify accepted request as barrier hit when addr == barrier_addr_i, write=0, participate_i[i]=1.
REQ-021 SHALL move hit Idle->Arrived; any other accepted request Idle->Respond with error=1, data=0; rsp_valid_o next cycle.
REQ-022 SHALL assert release when participate_i != 0 and every participating port is registered Arrived; evaluated on registered state only.
REQ-023 SHALL, on release, move all Arrived ports to Respond with data = zero-extended generation_o before increment, error=0.
REQ-024 SHALL increment generation_o by 1 per release, wrapping 255->0.
REQ-025 SHALL pulse release_o the cycle release is true; rsp_valid_o rises one cycle later.
REQ-026 SHALL hold rsp_valid_o/data/error stable until rsp_ready_i; Respond->Idle on handshake; new request accepted the following cycle.
REQ-027 SHALL not count an arrival accepted in the release cycle toward that release; it waits for the next generation.
REQ-028 SHALL, if participate_i drops a port while Arrived, keep it Arrived; release uses current participate_i each cycle.
REQ-029 SHALL never release with participate_i == 0; Arrived ports then wait indefinitely.

Reset
REQ-030 SHALL reset all FSMs to Idle, generation_o=0, release_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_error_o=0, req_ready_o=all ones.
REQ-031 SHALL on reset assertion mid-barrier discard all arrivals and pending responses immediately.

Structure
REQ-032 SHALL place port-state enum and generation width constant in shared package spatz_barrier_pkg.
REQ-033 SHALL instantiate per-port sub-module spatz_barrier_port_fsm (state, response registers); top holds release logic and generation counter.

Verification
REQ-034 SHALL cover: NrPorts=4, participate=4'hF, ports 0..3 hit at cycles 0,2,5,9 -> release_o at 10, all rsp_valid at 11, data=0, generation_o=1.
REQ-035 SHALL cover: participate=4'b0011, ports 0,1 hit -> release, ports 2,3 idle and unaffected; port 3 hit -> error response next cycle.
REQ-036 SHALL cover: write to barrier_addr_i and read of barrier_addr_i+4 -> error=1, data=0 one cycle after accept, no arrival recorded.
REQ-037 SHALL cover: 256 consecutive barriers -> responses carry 0..255, generation_o wraps to 0.
REQ-038 SHALL cover: rsp_ready_i held low 5 cycles on port 2 after release -> rsp_valid_o and data stable; port 2 req_ready_o low until handshake.
REQ-039 SHALL cover: rst_ni low with 3 of 4 ports Arrived -> all Idle, generation_o=0; fresh 4-port barrier then returns data 0.

Source files
------------

// File: rtl/spatz_barrier_pkg.sv
// Shared definitions for the barrier responder.
//   port_state_e : per-port FSM state (Idle / Arrived / Respond)
//   GenWidth     : width of the completed-barrier generation counter
//   gen_t        : generation counter type
//   gen_next()   : generation increment, wraps modulo 2**GenWidth
package spatz_barrier_pkg;

    localparam int unsigned GenWidth = 8;

    typedef logic [GenWidth-1:0] gen_t;

    typedef enum logic [1:0] {
        PORT_IDLE    = 2'd0,
        PORT_ARRIVED = 2'd1,
        PORT_RESPOND = 2'd2
    } port_state_e;

    function automatic gen_t gen_next(input gen_t gen);
        return gen + gen_t'(1);
    endfunction

endpackage

// File: rtl/spatz_barrier_responder_if.sv
// Per-port request/response bus between the cores and the barrier responder.
//   req_valid_i/req_ready_o : request handshake, one bit per port
//   req_addr_i/req_write_i  : request address and write flag per port
//   rsp_valid_o/rsp_ready_i : response handshake, one bit per port
//   rsp_data_o/rsp_error_o  : response payload and error flag per port
// The _i/_o suffixes are as seen from the responder.
// Modports: master = core side, slave = responder side.
interface spatz_barrier_responder_if #(
    parameter int unsigned NrPorts   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [NrPorts-1:0]                req_valid_i;
    logic [NrPorts-1:0]                req_ready_o;
    logic [NrPorts-1:0][AddrWidth-1:0] req_addr_i;
    logic [NrPorts-1:0]                req_write_i;
    logic [NrPorts-1:0]                rsp_valid_o;
    logic [NrPorts-1:0]                rsp_ready_i;
    logic [NrPorts-1:0][DataWidth-1:0] rsp_data_o;
    logic [NrPorts-1:0]                rsp_error_o;

    modport master (
        output req_valid_i, req_addr_i, req_write_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o
    );
endinterface

// File: rtl/spatz_barrier_port_fsm.sv
// One core port of the barrier responder: Idle / Arrived / Respond FSM plus
// the registered response payload.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   barrier_addr_i   : address that identifies a barrier arrival
//   participate_i    : this port takes part in the current barrier
//   release_i        : barrier release from the top (registered-state based)
//   gen_i            : generation value returned on release
//   req_*            : request handshake and payload
//   rsp_*            : response handshake and payload
//   arrived_o        : port is registered in the Arrived state
module spatz_barrier_port_fsm
    import spatz_barrier_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] barrier_addr_i,
    input  logic                 participate_i,
    input  logic                 release_i,
    input  gen_t                 gen_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_error_o,
    output logic                 arrived_o
);

    port_state_e          state_reg;
    logic                 rsp_valid_reg;
    logic [DataWidth-1:0] rsp_data_reg;
    logic                 rsp_error_reg;

    logic accept;
    logic hit;

    assign req_ready_o = (state_reg == PORT_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    // Only a participating read of the barrier register counts as an arrival.
    assign hit         = (req_addr_i == barrier_addr_i) && !req_write_i && participate_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= PORT_IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                PORT_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            state_reg <= PORT_ARRIVED;
                        end else begin
                            state_reg     <= PORT_RESPOND;
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= '0;
                            rsp_error_reg <= 1'b1;
                        end
                    end
                end
                PORT_ARRIVED: begin
                    // Stays here even if participation is withdrawn; any
                    // release frees every Arrived port.
                    if (release_i) begin
                        state_reg     <= PORT_RESPOND;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= DataWidth'(gen_i);
                        rsp_error_reg <= 1'b0;
                    end
                end
                PORT_RESPOND: begin
                    if (rsp_ready_i) begin
                        state_reg     <= PORT_IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_data_reg  <= '0;
                        rsp_error_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= PORT_IDLE;
                    rsp_valid_reg <= 1'b0;
                    rsp_data_reg  <= '0;
                    rsp_error_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign rsp_error_o = rsp_error_reg;
    assign arrived_o   = (state_reg == PORT_ARRIVED);

endmodule

// File: rtl/spatz_barrier_responder.sv
// Barrier responder: cores read a barrier register; each read blocks until all
// participating ports have arrived, then every waiting port gets the current
// generation number back and the generation counter advances.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   barrier_addr_i  : barrier register address
//   participate_i   : ports taking part in the barrier
//   bus             : per-port request/response bus (slave side)
//   generation_o    : number of completed barriers (wraps at 255)
//   release_o       : high during the cycle the barrier releases
module spatz_barrier_responder
    import spatz_barrier_pkg::*;
#(
    parameter int unsigned NrPorts   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] barrier_addr_i,
    input  logic [NrPorts-1:0]   participate_i,
    spatz_barrier_responder_if.slave bus,
    output logic [GenWidth-1:0]  generation_o,
    output logic                 release_o
);

    logic [NrPorts-1:0] arrived;
    logic [NrPorts-1:0] missing;
    logic               release_now;
    gen_t               generation_reg;

    for (genvar gi = 0; gi < NrPorts; gi++) begin : g_port
        spatz_barrier_port_fsm #(
            .AddrWidth (AddrWidth),
            .DataWidth (DataWidth)
        ) u_fsm (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .barrier_addr_i (barrier_addr_i),
            .participate_i  (participate_i[gi]),
            .release_i      (release_now),
            .gen_i          (generation_reg),
            .req_valid_i    (bus.req_valid_i[gi]),
            .req_ready_o    (bus.req_ready_o[gi]),
            .req_addr_i     (bus.req_addr_i[gi]),
            .req_write_i    (bus.req_write_i[gi]),
            .rsp_valid_o    (bus.rsp_valid_o[gi]),
            .rsp_ready_i    (bus.rsp_ready_i[gi]),
            .rsp_data_o     (bus.rsp_data_o[gi]),
            .rsp_error_o    (bus.rsp_error_o[gi]),
            .arrived_o      (arrived[gi])
        );
    end

    // Release looks only at registered Arrived state, so an arrival accepted
    // in the release cycle belongs to the next generation.
    assign missing     = participate_i & ~arrived;
    assign release_now = (|participate_i) && !(|missing);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            generation_reg <= '0;
        end else if (release_now) begin
            generation_reg <= gen_next(generation_reg);
        end
    end

    assign generation_o = generation_reg;
    assign release_o    = release_now;

endmodule

// File: tb/tb_spatz_barrier_responder.sv
module tb_spatz_barrier_responder;
    import spatz_barrier_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] BAR = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] barrier_addr;
    logic [NP-1:0] participate;
    logic [7:0]    generation;
    logic          release_w;

    int checks = 0;
    int errors = 0;

    spatz_barrier_responder_if #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus ();

    spatz_barrier_responder #(
        .NrPorts   (NP),
        .AddrWidth (AW),
        .DataWidth (DW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .barrier_addr_i (barrier_addr),
        .participate_i  (participate),
        .bus            (bus),
        .generation_o   (generation),
        .release_o      (release_w)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i = '0;
        bus.req_write_i = '0;
        bus.rsp_ready_i = '1;
        for (int i = 0; i < NP; i++) bus.req_addr_i[i] = BAR;
    endtask

    task automatic test_reset();
        barrier_addr = BAR;
        participate  = '0;
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL reset_ready got %h want %h", bus.req_ready_o, 4'hF); end
        checks++; if (bus.rsp_valid_o !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid got %h want %h", bus.rsp_valid_o, 4'h0); end
        checks++; if (bus.rsp_data_o !== 128'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data_o); end
        checks++; if (bus.rsp_error_o !== 4'h0) begin errors++; $display("FAIL reset_rsp_error got %h want %h", bus.rsp_error_o, 4'h0); end
        checks++; if (generation !== 8'd0) begin errors++; $display("FAIL reset_generation got %0d want 0", generation); end
        checks++; if (release_w !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", release_w); end
        step();
        rst_n = 1'b1;
        step();
        $display("test_reset: outputs idle under reset");
    endtask

    task automatic test_all_ports();
        logic [NP-1:0] exp_ready;
        int hc [NP];
        hc[0] = 0; hc[1] = 2; hc[2] = 5; hc[3] = 9;
        participate = 4'hF;
        for (int c = 0; c <= 10; c++) begin
            for (int i = 0; i < NP; i++) begin
                bus.req_valid_i[i] = (c == hc[i]);
                exp_ready[i]       = (c <= hc[i]);
            end
            checks++; if (release_w !== (c == 10)) begin errors++; $display("FAIL all_release c=%0d got %b want %b", c, release_w, (c == 10)); end
            checks++; if (bus.rsp_valid_o !== 4'h0) begin errors++; $display("FAIL all_rsp_early c=%0d got %h want 0", c, bus.rsp_valid_o); end
            checks++; if (bus.req_ready_o !== exp_ready) begin errors++; $display("FAIL all_ready c=%0d got %h want %h", c, bus.req_ready_o, exp_ready); end
            step();
        end
        bus.req_valid_i = '0;
        checks++; if (bus.rsp_valid_o !== 4'hF) begin errors++; $display("FAIL all_rsp_valid got %h want F", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o !== 128'h0) begin errors++; $display("FAIL all_rsp_data got %h want 0", bus.rsp_data_o); end
        checks++; if (bus.rsp_error_o !== 4'h0) begin errors++; $display("FAIL all_rsp_error got %h want 0", bus.rsp_error_o); end
        checks++; if (generation !== 8'd1) begin errors++; $display("FAIL all_generation got %0d want 1", generation); end
        checks++; if (release_w !== 1'b0) begin errors++; $display("FAIL all_release_after got %b want 0", release_w); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'h0) begin errors++; $display("FAIL all_rsp_done got %h want 0", bus.rsp_valid_o); end
        checks++; if (bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL all_ready_done got %h want F", bus.req_ready_o); end
        $display("test_all_ports: 4 arrivals at 0,2,5,9 -> release at 10, gen=%0d", generation);
    endtask

    task automatic test_subset();
        participate = 4'b0011;
        bus.req_valid_i = 4'b0011;
        step();
        bus.req_valid_i = '0;
        checks++; if (release_w !== 1'b1) begin errors++; $display("FAIL sub_release got %b want 1", release_w); end
        checks++; if (bus.req_ready_o !== 4'b1100) begin errors++; $display("FAIL sub_ready_arr got %b want 1100", bus.req_ready_o); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'b0011) begin errors++; $display("FAIL sub_rsp_valid got %b want 0011", bus.rsp_valid_o); end
        checks++; if (bus.rsp_data_o[0] !== 32'd1 || bus.rsp_data_o[1] !== 32'd1) begin errors++; $display("FAIL sub_rsp_data got %h/%h want 1/1", bus.rsp_data_o[0], bus.rsp_data_o[1]); end
        checks++; if (generation !== 8'd2) begin errors++; $display("FAIL sub_generation got %0d want 2", generation); end
        checks++; if (bus.req_ready_o !== 4'b1100) begin errors++; $display("FAIL sub_ready_rsp got %b want 1100", bus.req_ready_o); end
        bus.req_valid_i = 4'b1000;
        step();
        bus.req_valid_i = '0;
        checks++; if (bus.rsp_valid_o !== 4'b1000) begin errors++; $display("FAIL sub_p3_valid got %b want 1000", bus.rsp_valid_o); end
        checks++; if (bus.rsp_error_o !== 4'b1000) begin errors++; $display("FAIL sub_p3_error got %b want 1000", bus.rsp_error_o); end
        checks++; if (bus.rsp_data_o[3] !== 32'd0) begin errors++; $display("FAIL sub_p3_data got %h want 0", bus.rsp_data_o[3]); end
        checks++; if (generation !== 8'd2) begin errors++; $display("FAIL sub_gen_hold got %0d want 2", generation); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'h0 || bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL sub_idle got v=%b r=%b want 0000/1111", bus.rsp_valid_o, bus.req_ready_o); end
        $display("test_subset: ports 0,1 released with data 1; port 3 error response");
    endtask

    task automatic test_errors();
        participate        = 4'b0011;
        bus.req_write_i[0] = 1'b1;
        bus.req_addr_i[1]  = BAR + 32'd4;
        bus.req_valid_i    = 4'b0011;
        step();
        bus.req_valid_i = '0;
        idle_inputs();
        checks++; if (bus.rsp_valid_o !== 4'b0011) begin errors++; $display("FAIL err_valid got %b want 0011", bus.rsp_valid_o); end
        checks++; if (bus.rsp_error_o !== 4'b0011) begin errors++; $display("FAIL err_error got %b want 0011", bus.rsp_error_o); end
        checks++; if (bus.rsp_data_o !== 128'h0) begin errors++; $display("FAIL err_data got %h want 0", bus.rsp_data_o); end
        checks++; if (release_w !== 1'b0) begin errors++; $display("FAIL err_release got %b want 0", release_w); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'h0 || bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL err_idle got v=%b r=%b want 0000/1111", bus.rsp_valid_o, bus.req_ready_o); end
        checks++; if (generation !== 8'd2) begin errors++; $display("FAIL err_generation got %0d want 2", generation); end
        $display("test_errors: write and wrong-address read -> error, no arrival");
    endtask

    task automatic test_participate_drop();
        participate     = 4'b0011;
        bus.req_valid_i = 4'b0001;
        step();
        bus.req_valid_i = '0;
        participate     = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            checks++; if (release_w !== 1'b0) begin errors++; $display("FAIL drop_release k=%0d got %b want 0", k, release_w); end
            checks++; if (bus.req_ready_o !== 4'b1110 || bus.rsp_valid_o !== 4'h0) begin errors++; $display("FAIL drop_wait k=%0d got r=%b v=%b want 1110/0000", k, bus.req_ready_o, bus.rsp_valid_o); end
            step();
        end
        participate = 4'b0001;
        #1;
        checks++; if (release_w !== 1'b1) begin errors++; $display("FAIL drop_release_now got %b want 1", release_w); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_data_o[0] !== 32'd2) begin errors++; $display("FAIL drop_rsp got v=%b d=%h want 0001/2", bus.rsp_valid_o, bus.rsp_data_o[0]); end
        checks++; if (generation !== 8'd3) begin errors++; $display("FAIL drop_generation got %0d want 3", generation); end
        step();
        $display("test_participate_drop: arrived port waits with participate=0, released later with data 2");
    endtask

    task automatic test_back_to_back_backpressure();
        participate     = 4'hF;
        bus.req_valid_i = 4'hF;
        step();
        bus.req_valid_i = '0;
        bus.rsp_ready_i = 4'b1011;
        checks++; if (release_w !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", release_w); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'hF) begin errors++; $display("FAIL bp_all_valid got %h want F", bus.rsp_valid_o); end
        checks++; if (generation !== 8'd4) begin errors++; $display("FAIL bp_generation got %0d want 4", generation); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.rsp_valid_o[2] !== 1'b1 || bus.rsp_data_o[2] !== 32'd3 || bus.rsp_error_o[2] !== 1'b0) begin errors++; $display("FAIL bp_hold k=%0d got v=%b d=%h e=%b want 1/3/0", k, bus.rsp_valid_o[2], bus.rsp_data_o[2], bus.rsp_error_o[2]); end
            checks++; if (bus.req_ready_o[2] !== 1'b0) begin errors++; $display("FAIL bp_ready2 k=%0d got %b want 0", k, bus.req_ready_o[2]); end
            step();
        end
        checks++; if (bus.rsp_valid_o !== 4'b0100 || bus.req_ready_o !== 4'b1011) begin errors++; $display("FAIL bp_others got v=%b r=%b want 0100/1011", bus.rsp_valid_o, bus.req_ready_o); end
        bus.rsp_ready_i = 4'hF;
        step();
        checks++; if (bus.rsp_valid_o !== 4'h0 || bus.req_ready_o !== 4'hF) begin errors++; $display("FAIL bp_done got v=%b r=%b want 0000/1111", bus.rsp_valid_o, bus.req_ready_o); end
        $display("test_back_to_back_backpressure: port 2 held data 3 for 5 cycles");
    endtask

    task automatic test_reset_mid();
        participate     = 4'hF;
        bus.req_valid_i = 4'b0111;
        step();
        bus.req_valid_i = '0;
        checks++; if (bus.req_ready_o !== 4'b1000 || release_w !== 1'b0) begin errors++; $display("FAIL rm_arrived got r=%b rel=%b want 1000/0", bus.req_ready_o, release_w); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.req_ready_o !== 4'hF || bus.rsp_valid_o !== 4'h0) begin errors++; $display("FAIL rm_cleared got r=%b v=%b want 1111/0000", bus.req_ready_o, bus.rsp_valid_o); end
        checks++; if (generation !== 8'd0) begin errors++; $display("FAIL rm_generation got %0d want 0", generation); end
        step();
        rst_n = 1'b1;
        step();
        bus.req_valid_i = 4'hF;
        step();
        bus.req_valid_i = '0;
        checks++; if (release_w !== 1'b1) begin errors++; $display("FAIL rm_release got %b want 1", release_w); end
        step();
        checks++; if (bus.rsp_valid_o !== 4'hF || bus.rsp_data_o !== 128'h0) begin errors++; $display("FAIL rm_fresh got v=%h d=%h want F/0", bus.rsp_valid_o, bus.rsp_data_o); end
        checks++; if (generation !== 8'd1) begin errors++; $display("FAIL rm_gen_after got %0d want 1", generation); end
        step();
        $display("test_reset_mid: arrivals discarded, fresh barrier returned 0");
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        step();
        participate = 4'b0001;
        for (int k = 0; k < 256; k++) begin
            bus.req_valid_i = 4'b0001;
            step();
            bus.req_valid_i = '0;
            checks++; if (release_w !== 1'b1) begin errors++; $display("FAIL wrap_release k=%0d got %b want 1", k, release_w); end
            step();
            checks++; if (bus.rsp_valid_o[0] !== 1'b1 || bus.rsp_data_o[0] !== 32'(k)) begin errors++; $display("FAIL wrap_data k=%0d got v=%b d=%0d want 1/%0d", k, bus.rsp_valid_o[0], bus.rsp_data_o[0], k); end
            checks++; if (generation !== 8'(k + 1)) begin errors++; $display("FAIL wrap_gen k=%0d got %0d want %0d", k, generation, 8'(k + 1)); end
            $display("test_wrap: barrier %0d data %0d gen %0d", k, bus.rsp_data_o[0], generation);
            step();
        end
        checks++; if (generation !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", generation); end
    endtask

    initial begin
        test_reset();
        test_all_ports();
        test_subset();
        test_errors();
        test_participate_drop();
        test_back_to_back_backpressure();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
